// File: rtl/uart_sum_tx.sv
// rtl/uart_sum_tx.sv - 8N1 UART transmitter for the 65-bit adder result (carry byte, then sum MSB..LSB)
module uart_sum_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [63:0] sum_i,
    input  logic        cout_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        tx_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0] LAST_BYTE = 4'd8;
    localparam logic [2:0] LAST_BIT  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t           state, nxt_state;
    logic [71:0]      payload, nxt_payload;
    logic [3:0]       byte_idx, nxt_byte_idx;
    logic [2:0]       bit_idx, nxt_bit_idx;
    logic [CNT_W-1:0] baud_cnt, nxt_baud_cnt;
    logic             tx_q, nxt_tx;

    logic [7:0]       cur_byte;
    logic [2:0]       next_bit;
    logic             bit_end;

    assign bit_end  = (baud_cnt == CNT_MAX);
    assign next_bit = bit_idx + 3'd1;

    // Select the byte being serialised; byte 0 carries the adder carry-out in its LSB
    always_comb begin
        cur_byte = 8'h00;
        case (byte_idx)
            4'd0:    cur_byte = payload[71:64];
            4'd1:    cur_byte = payload[63:56];
            4'd2:    cur_byte = payload[55:48];
            4'd3:    cur_byte = payload[47:40];
            4'd4:    cur_byte = payload[39:32];
            4'd5:    cur_byte = payload[31:24];
            4'd6:    cur_byte = payload[23:16];
            4'd7:    cur_byte = payload[15:8];
            4'd8:    cur_byte = payload[7:0];
            default: cur_byte = 8'h00;
        endcase
    end

    // State register; the line register is updated from the same decode so tx_o never glitches
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // Datapath registers: payload, frame/bit indices, baud counter and the serial line
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            payload  <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            tx_q     <= 1'b1;
        end else begin
            payload  <= nxt_payload;
            byte_idx <= nxt_byte_idx;
            bit_idx  <= nxt_bit_idx;
            baud_cnt <= nxt_baud_cnt;
            tx_q     <= nxt_tx;
        end
    end

    // Next-state and next-datapath decode; the line value for each bit is registered on entry
    always_comb begin
        nxt_state    = state;
        nxt_payload  = payload;
        nxt_byte_idx = byte_idx;
        nxt_bit_idx  = bit_idx;
        nxt_baud_cnt = baud_cnt;
        nxt_tx       = tx_q;

        case (state)
            ST_IDLE: begin
                nxt_tx = 1'b1;
                if (start_i) begin
                    nxt_state    = ST_START;
                    nxt_payload  = {7'b0, cout_i, sum_i};
                    nxt_byte_idx = '0;
                    nxt_bit_idx  = '0;
                    nxt_baud_cnt = '0;
                    nxt_tx       = 1'b0;
                end
            end

            ST_START: begin
                if (bit_end) begin
                    nxt_state    = ST_DATA;
                    nxt_bit_idx  = '0;
                    nxt_baud_cnt = '0;
                    nxt_tx       = cur_byte[0];
                end else begin
                    nxt_baud_cnt = baud_cnt + 1'b1;
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    nxt_baud_cnt = '0;
                    if (bit_idx == LAST_BIT) begin
                        nxt_state = ST_STOP;
                        nxt_tx    = 1'b1;
                    end else begin
                        nxt_bit_idx = next_bit;
                        nxt_tx      = cur_byte[next_bit];
                    end
                end else begin
                    nxt_baud_cnt = baud_cnt + 1'b1;
                end
            end

            ST_STOP: begin
                if (bit_end) begin
                    nxt_baud_cnt = '0;
                    if (byte_idx == LAST_BYTE) begin
                        nxt_state = ST_DONE;
                        nxt_tx    = 1'b1;
                    end else begin
                        // Next frame's start bit follows the stop bit with no idle gap
                        nxt_state    = ST_START;
                        nxt_byte_idx = byte_idx + 4'd1;
                        nxt_tx       = 1'b0;
                    end
                end else begin
                    nxt_baud_cnt = baud_cnt + 1'b1;
                end
            end

            ST_DONE: begin
                nxt_tx       = 1'b1;
                nxt_state    = ST_IDLE;
                nxt_baud_cnt = '0;
                // A request in the done cycle is accepted immediately, leaving one idle-high cycle
                if (start_i) begin
                    nxt_state    = ST_START;
                    nxt_payload  = {7'b0, cout_i, sum_i};
                    nxt_byte_idx = '0;
                    nxt_bit_idx  = '0;
                    nxt_tx       = 1'b0;
                end
            end

            default: begin
                nxt_state = ST_IDLE;
                nxt_tx    = 1'b1;
            end
        endcase
    end

    assign busy_o = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
    assign done_o = (state == ST_DONE);
    assign tx_o   = tx_q;

endmodule
